neander_x_exec_unit: RTL and testbench

Execute/writeback stage of the NEANDER-X CPU, directly downstream of the ALU. It accepts one operation per request, drives the ALU's operand and opcode inputs, and captures the ALU outputs into the architectural registers AC and Y and the N/Z/C flags. An optional iterative 8-cycle divider adds DIV. The control FSM issues requests; AC, Y and the flags feed back to the datapath and branch logic.

---
 rtl/neander_x_pkg.sv | 31 +++
 rtl/neander_x_exec_unit_if.sv | 13 +
 rtl/neander_x_divider.sv | 52 +++++
 rtl/neander_x_exec_unit.sv | 157 +++++++++++++++
 tb/tb_neander_x_exec_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/neander_x_pkg.sv
// Shared types and constants for the NEANDER-X execute/writeback stage.
package neander_x_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_NOT   = 4'b0101,
    OP_SHL   = 4'b0110,
    OP_SHR   = 4'b0111,
    OP_NEG   = 4'b1000,
    OP_MUL   = 4'b1001,
    OP_DIV   = 4'b1010,
    OP_LDY   = 4'b1011,
    OP_LDA   = 4'b1100,
    OP_SWAP  = 4'b1101,
    OP_NOP_E = 4'b1110,
    OP_NOP_F = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DIV  = 2'b10
  } exec_state_e;

  localparam int DIV_ITERATIONS = 8;

endpackage

// File: rtl/neander_x_exec_unit_if.sv
// Request handshake between the NEANDER-X control FSM (master) and the exec unit (slave).
interface neander_x_exec_unit_if;
  import neander_x_pkg::*;

  logic       req_valid;
  logic       req_ready;
  opcode_e    req_op;
  logic [7:0] req_operand;

  modport master (output req_valid, output req_op, output req_operand, input req_ready);
  modport slave  (input req_valid, input req_op, input req_operand, output req_ready);

endinterface

// File: rtl/neander_x_divider.sv
// Iterative restoring 8-bit divider, one quotient bit per cycle, MSB first.
// Only present when NEANDER_X_DIV_EN is defined.
`ifdef NEANDER_X_DIV_EN
module neander_x_divider
  import neander_x_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       last
);

  logic [7:0] rem_q;
  logic [7:0] quo_q;
  logic [2:0] count_q;
  logic [8:0] rem_shift;
  logic [8:0] trial;
  logic       q_bit;

  // Outputs are the result of the iteration taking place this cycle, so the
  // owner can commit on the same edge as the final iteration.
  always_comb begin
    rem_shift = {rem_q, quo_q[7]};
    trial     = rem_shift - {1'b0, divisor};
    q_bit     = ~trial[8];
    remainder = q_bit ? trial[7:0] : rem_shift[7:0];
    quotient  = {quo_q[6:0], q_bit};
    last      = (count_q == 3'(DIV_ITERATIONS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= 8'h00;
      quo_q   <= 8'h00;
      count_q <= 3'd0;
    end else if (start) begin
      rem_q   <= 8'h00;
      quo_q   <= dividend;
      count_q <= 3'd0;
    end else begin
      rem_q   <= remainder;
      quo_q   <= quotient;
      count_q <= count_q + 3'd1;
    end
  end

endmodule
`endif

// File: rtl/neander_x_exec_unit.sv
// NEANDER-X execute/writeback stage: drives the ALU and commits AC, Y and N/Z/C.
// Define NEANDER_X_DIV_EN to add the iterative DIV opcode.
module neander_x_exec_unit
  import neander_x_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  neander_x_exec_unit_if.slave        req,
  output logic [7:0]                  alu_a,
  output logic [7:0]                  alu_b,
  output logic [3:0]                  alu_op,
  input  logic [7:0]                  alu_result,
  input  logic [7:0]                  alu_mul_high,
  input  logic                        alu_carry,
  output logic [7:0]                  ac,
  output logic [7:0]                  y,
  output logic                        flag_n,
  output logic                        flag_z,
  output logic                        flag_c,
  output logic                        busy,
  output logic                        done
);

  exec_state_e state_q, state_next;
  opcode_e     op_q;
  logic [7:0]  operand_q;
  logic [7:0]  ac_d, y_d;
  logic        c_d, ac_write, done_d, div_start;
  logic        accept;

`ifdef NEANDER_X_DIV_EN
  logic [7:0] div_quotient, div_remainder;
  logic       div_last;

  neander_x_divider u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (ac),
    .divisor   (operand_q),
    .quotient  (div_quotient),
    .remainder (div_remainder),
    .last      (div_last)
  );
`endif

  assign req.req_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign accept        = req.req_valid && (state_q == ST_IDLE);
  assign alu_a         = ac;
  assign alu_b         = operand_q;
  assign alu_op        = (op_q >= OP_DIV) ? 4'b0000 : op_q;

  // Next-state and commit values; N/Z only follow AC when the op actually writes AC.
  always_comb begin
    state_next = state_q;
    ac_d       = ac;
    y_d        = y;
    c_d        = flag_c;
    ac_write   = 1'b0;
    done_d     = 1'b0;
    div_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_IDLE;
        done_d     = 1'b1;
        case (op_q)
          OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_NEG: begin
            ac_d     = alu_result;
            c_d      = alu_carry;
            ac_write = 1'b1;
          end
          OP_MUL: begin
            ac_d     = alu_result;
            y_d      = alu_mul_high;
            c_d      = alu_carry;
            ac_write = 1'b1;
          end
          OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            ac_d     = alu_result;
            ac_write = 1'b1;
          end
`ifdef NEANDER_X_DIV_EN
          OP_DIV: begin
            if (operand_q == 8'h00) begin
              ac_d     = 8'hFF;
              y_d      = ac;
              c_d      = 1'b1;
              ac_write = 1'b1;
            end else begin
              state_next = ST_DIV;
              done_d     = 1'b0;
              div_start  = 1'b1;
            end
          end
`endif
          OP_LDY: y_d = operand_q;
          OP_LDA: begin
            ac_d     = operand_q;
            ac_write = 1'b1;
          end
          OP_SWAP: begin
            ac_d     = y;
            y_d      = ac;
            ac_write = 1'b1;
          end
          default: ;
        endcase
      end
`ifdef NEANDER_X_DIV_EN
      ST_DIV: begin
        if (div_last) begin
          ac_d       = div_quotient;
          y_d        = div_remainder;
          c_d        = 1'b0;
          ac_write   = 1'b1;
          done_d     = 1'b1;
          state_next = ST_IDLE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      operand_q <= 8'h00;
      ac        <= 8'h00;
      y         <= 8'h00;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_next;
      if (accept) begin
        op_q      <= req.req_op;
        operand_q <= req.req_operand;
      end
      ac     <= ac_d;
      y      <= y_d;
      flag_c <= c_d;
      if (ac_write) begin
        flag_n <= ac_d[7];
        flag_z <= (ac_d == 8'h00);
      end
      done <= done_d;
    end
  end

endmodule

// File: tb/tb_neander_x_exec_unit.sv
// Self-checking bench for neander_x_exec_unit; expectations follow NEANDER_X_DIV_EN.
module tb_neander_x_exec_unit;
  import neander_x_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] alu_a, alu_b, alu_result, alu_mul_high, ac, y;
  logic [3:0] alu_op;
  logic       alu_carry, flag_n, flag_z, flag_c, busy, done;
  int         tests_run = 0;
  int         tests_failed = 0;

  always #5 clk = ~clk;

  neander_x_exec_unit_if req_if ();

  neander_x_exec_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req_if),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_mul_high (alu_mul_high),
    .alu_carry    (alu_carry),
    .ac           (ac),
    .y            (y),
    .flag_n       (flag_n),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .busy         (busy),
    .done         (done)
  );

  // Behavioural ALU standing in for the real upstream ALU.
  logic [8:0]  wide;
  logic [15:0] prod;
  always_comb begin
    alu_result   = 8'h00;
    alu_mul_high = 8'h00;
    alu_carry    = 1'b0;
    wide         = 9'h000;
    prod         = 16'h0000;
    case (alu_op)
      4'd0: begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = wide[7:0]; alu_carry = wide[8]; end
      4'd1: begin wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_result = wide[7:0]; alu_carry = wide[8]; end
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a ^ alu_b;
      4'd5: alu_result = ~alu_a;
      4'd6: begin alu_result = {alu_a[6:0], 1'b0}; alu_carry = alu_a[7]; end
      4'd7: begin alu_result = {1'b0, alu_a[7:1]}; alu_carry = alu_a[0]; end
      4'd8: begin alu_result = 8'h00 - alu_a; alu_carry = |alu_a; end
      4'd9: begin
        prod         = {8'h00, alu_a} * {8'h00, alu_b};
        alu_result   = prod[7:0];
        alu_mul_high = prod[15:8];
        alu_carry    = |prod[15:8];
      end
      default: ;
    endcase
  end

  typedef struct {
    opcode_e    op;
    logic [7:0] operand;
    logic [7:0] exp_ac;
    logic [7:0] exp_y;
    logic       exp_n;
    logic       exp_z;
    logic       exp_c;
  } vec_t;

  vec_t vecs [19];

`ifdef NEANDER_X_DIV_EN
  localparam int ABORT_WAIT = 4;
`else
  localparam int ABORT_WAIT = 0;
`endif

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issues one request from a falling edge and returns the number of falling
  // edges after the accepting edge until done is seen.
  task automatic applyStimulus(input opcode_e op, input logic [7:0] operand,
                               input bit hold, output int lat);
    int waited = 0;
    while (!req_if.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_if.req_ready) checkOutput("ready_timeout", 0, 1);
    req_if.req_valid   = 1'b1;
    req_if.req_op      = op;
    req_if.req_operand = operand;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold) begin
        req_if.req_valid   = 1'b0;
        req_if.req_op      = OP_NOP_F;
        req_if.req_operand = ~operand;
      end
      if (hold && lat == 5) begin
        checkOutput("busy_mid_div", int'(busy), 1);
        checkOutput("ready_mid_div", int'(req_if.req_ready), 0);
      end
    end while (!done && lat < 30);
    req_if.req_valid = 1'b0;
    if (!done) checkOutput("done_timeout", 0, 1);
  endtask

  initial begin
    int lat;
    int done_cnt;

    vecs[0]  = '{OP_LDA,   8'h7F, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{OP_ADD,   8'h01, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{OP_LDA,   8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{OP_ADD,   8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{OP_AND,   8'h0F, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{OP_LDA,   8'h10, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{OP_MUL,   8'h20, 8'h00, 8'h02, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{OP_SWAP,  8'h00, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{OP_LDY,   8'h81, 8'h02, 8'h81, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{OP_SUB,   8'h05, 8'hFD, 8'h81, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{OP_SHR,   8'h00, 8'h7E, 8'h81, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{OP_SHL,   8'h00, 8'hFC, 8'h81, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{OP_OR,    8'h03, 8'hFF, 8'h81, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{OP_XOR,   8'hF0, 8'h0F, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{OP_NOT,   8'h00, 8'hF0, 8'h81, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{OP_NEG,   8'h00, 8'h10, 8'h81, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{OP_NOP_E, 8'h55, 8'h10, 8'h81, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{OP_LDA,   8'h00, 8'h00, 8'h81, 1'b0, 1'b1, 1'b1};
    vecs[18] = '{OP_SWAP,  8'h00, 8'h81, 8'h00, 1'b1, 1'b0, 1'b1};

    req_if.req_valid   = 1'b0;
    req_if.req_op      = OP_ADD;
    req_if.req_operand = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_ac", int'(ac), 0);
    checkOutput("rst_y", int'(y), 0);
    checkOutput("rst_flags", int'({flag_n, flag_z, flag_c}), 0);
    checkOutput("rst_alu", int'({alu_a, alu_b, alu_op}), 0);
    checkOutput("rst_done_busy", int'({done, busy}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", int'(req_if.req_ready), 1);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].op, vecs[i].operand, 1'b0, lat);
      checkOutput($sformatf("v%0d_latency", i), lat, 2);
      checkOutput($sformatf("v%0d_ac", i), int'(ac), int'(vecs[i].exp_ac));
      checkOutput($sformatf("v%0d_y", i), int'(y), int'(vecs[i].exp_y));
      checkOutput($sformatf("v%0d_n", i), int'(flag_n), int'(vecs[i].exp_n));
      checkOutput($sformatf("v%0d_z", i), int'(flag_z), int'(vecs[i].exp_z));
      checkOutput($sformatf("v%0d_c", i), int'(flag_c), int'(vecs[i].exp_c));
      checkOutput($sformatf("v%0d_alu_a", i), int'(alu_a), int'(vecs[i].exp_ac));
    end

    // 200 / 7 with req_valid held high while busy
    applyStimulus(OP_LDA, 8'hC8, 1'b0, lat);
    checkOutput("div_lda_ac", int'(ac), 8'hC8);
    applyStimulus(OP_DIV, 8'h07, 1'b1, lat);
`ifdef NEANDER_X_DIV_EN
    checkOutput("div_latency", lat, 10);
    checkOutput("div_ac", int'(ac), 8'h1C);
    checkOutput("div_y", int'(y), 8'h04);
    checkOutput("div_flags", int'({flag_n, flag_z, flag_c}), 3'b000);
`else
    checkOutput("div_latency", lat, 2);
    checkOutput("div_ac", int'(ac), 8'hC8);
    checkOutput("div_y", int'(y), 8'h00);
    checkOutput("div_flags", int'({flag_n, flag_z, flag_c}), 3'b101);
`endif
    @(negedge clk);
    checkOutput("done_one_cycle", int'(done), 0);
    checkOutput("idle_after_div", int'({busy, req_if.req_ready}), 2'b01);

    // Divide by zero
    applyStimulus(OP_LDA, 8'h55, 1'b0, lat);
    applyStimulus(OP_DIV, 8'h00, 1'b0, lat);
    checkOutput("div0_latency", lat, 2);
`ifdef NEANDER_X_DIV_EN
    checkOutput("div0_ac", int'(ac), 8'hFF);
    checkOutput("div0_y", int'(y), 8'h55);
    checkOutput("div0_flags", int'({flag_n, flag_z, flag_c}), 3'b101);
`else
    checkOutput("div0_ac", int'(ac), 8'h55);
    checkOutput("div0_y", int'(y), 8'h00);
    checkOutput("div0_flags", int'({flag_n, flag_z, flag_c}), 3'b001);
`endif

    // Reset asserted in the middle of an operation
    applyStimulus(OP_LDA, 8'hFA, 1'b0, lat);
    checkOutput("abort_lda_ac", int'(ac), 8'hFA);
    req_if.req_valid   = 1'b1;
    req_if.req_op      = OP_DIV;
    req_if.req_operand = 8'h03;
    @(posedge clk);
    @(negedge clk);
    req_if.req_valid = 1'b0;
    repeat (ABORT_WAIT) @(negedge clk);
    checkOutput("abort_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ac", int'(ac), 0);
    checkOutput("abort_y", int'(y), 0);
    checkOutput("abort_flags", int'({flag_n, flag_z, flag_c}), 0);
    checkOutput("abort_alu", int'({alu_a, alu_b, alu_op}), 0);
    checkOutput("abort_done_busy", int'({done, busy}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("abort_no_done", done_cnt, 0);
    checkOutput("abort_ready", int'(req_if.req_ready), 1);
    checkOutput("abort_ac_after", int'(ac), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
